// File: rtl/cp_flag_servicer.sv
// ---------------------------------------------------------------------------
// cp_flag_servicer
// Consumer side of a bank of set/clear request-flag latches. Picks one pending
// flag by round-robin and hands it to a service agent over a req/ack
// handshake. Once the agent accepts, it sends a single-cycle clear pulse back
// to that channel's latch and then checks that the flag has actually dropped.
//
// Ports
//   sys_clk  : single system clock, rising edge
//   reset_n  : synchronous active-low reset
//   enable   : permits a new pick while idle
//   flag     : level outputs of the set/clear latches
//   clear    : registered one-hot clear pulse to the latches
//   svc_req  : registered service request to the agent
//   svc_id   : channel being serviced, valid while svc_req is high
//   svc_ack  : agent acceptance, only looked at while requesting
//   busy     : high in every state except idle
//   err      : sticky, a flag failed to drop within TIMEOUT cycles
//   err_clr  : clears err, takes priority over a same-cycle error
// ---------------------------------------------------------------------------
module cp_flag_servicer #(
  parameter int CHANNELS = 4,
  parameter int IDW      = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] flag,
  output logic [CHANNELS-1:0] clear,
  output logic                svc_req,
  output logic [IDW-1:0]      svc_id,
  input  logic                svc_ack,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_CLR       = 2'd2,
    S_WAIT_DROP = 2'd3
  } state_t;

  // The drop timer counts completed WAIT_DROP cycles; the error fires on the
  // cycle where the count has already reached TIMEOUT-1.
  localparam logic [3:0]          TO_LAST = 4'(TIMEOUT - 1);
  localparam logic [CHANNELS-1:0] ONE_HOT = {{(CHANNELS-1){1'b0}}, 1'b1};

  state_t                state_r,   state_nxt_s;
  logic [IDW-1:0]        last_r,    last_nxt_s;
  logic [IDW-1:0]        svc_id_r,  svc_id_nxt_s;
  logic                  svc_req_r, svc_req_nxt_s;
  logic [CHANNELS-1:0]   clear_r,   clear_nxt_s;
  logic                  busy_r,    busy_nxt_s;
  logic                  err_r,     err_nxt_s;
  logic [3:0]            cnt_r,     cnt_nxt_s;
  logic                  err_set_s;
  logic                  found_s;
  logic [IDW-1:0]        pick_s;

  // Round-robin search beginning one above the last serviced channel.
  always_comb begin
    logic [IDW-1:0] idx_v;
    logic           hit_v;
    found_s = 1'b0;
    pick_s  = {IDW{1'b0}};
    idx_v   = {IDW{1'b0}};
    hit_v   = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx_v   = IDW'((int'(last_r) + i) % CHANNELS);
      hit_v   = flag[idx_v] & ~found_s;
      pick_s  = hit_v ? idx_v : pick_s;
      found_s = found_s | hit_v;
    end
  end

  // Next-state and next-output decode for the service sequence.
  always_comb begin
    state_nxt_s   = state_r;
    last_nxt_s    = last_r;
    svc_id_nxt_s  = svc_id_r;
    svc_req_nxt_s = svc_req_r;
    clear_nxt_s   = {CHANNELS{1'b0}};
    cnt_nxt_s     = cnt_r;
    err_set_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (enable && found_s) begin
          state_nxt_s   = S_REQ;
          svc_req_nxt_s = 1'b1;
          svc_id_nxt_s  = pick_s;
        end else begin
          state_nxt_s   = S_IDLE;
        end
      end
      S_REQ: begin
        if (svc_ack) begin
          state_nxt_s   = S_CLR;
          svc_req_nxt_s = 1'b0;
          clear_nxt_s   = ONE_HOT << svc_id_r;
        end else begin
          state_nxt_s   = S_REQ;
        end
      end
      S_CLR: begin
        state_nxt_s = S_WAIT_DROP;
        cnt_nxt_s   = 4'd0;
      end
      S_WAIT_DROP: begin
        if (!flag[svc_id_r]) begin
          state_nxt_s = S_IDLE;
          last_nxt_s  = svc_id_r;
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = S_IDLE;
          last_nxt_s  = svc_id_r;
          err_set_s   = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s   = S_IDLE;
        svc_req_nxt_s = 1'b0;
      end
    endcase
    // A clear request in the same cycle beats a new error.
    err_nxt_s  = err_clr ? 1'b0 : (err_r | err_set_s);
    busy_nxt_s = (state_nxt_s != S_IDLE);
  end

  // State and registered outputs; reset is synchronous.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      last_r    <= IDW'(CHANNELS - 1);
      svc_id_r  <= {IDW{1'b0}};
      svc_req_r <= 1'b0;
      clear_r   <= {CHANNELS{1'b0}};
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      last_r    <= last_nxt_s;
      svc_id_r  <= svc_id_nxt_s;
      svc_req_r <= svc_req_nxt_s;
      clear_r   <= clear_nxt_s;
      busy_r    <= busy_nxt_s;
      err_r     <= err_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign clear   = clear_r;
  assign svc_req = svc_req_r;
  assign svc_id  = svc_id_r;
  assign busy    = busy_r;
  assign err     = err_r;

endmodule

// File: tb/tb_cp_flag_servicer.sv
// ---------------------------------------------------------------------------
// tb_cp_flag_servicer
// Directed bench for cp_flag_servicer. A small set/clear latch model drives
// the flag inputs (clear dominates set; selected channels can be made to
// ignore clear). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cp_flag_servicer;

  logic       sys_clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] flag;
  logic [3:0] clear;
  logic       svc_req;
  logic [1:0] svc_id;
  logic       svc_ack;
  logic       busy;
  logic       err;
  logic       err_clr;

  logic [3:0] set_v;
  logic [3:0] stuck_v;
  logic       lat_rst;
  logic [3:0] latch_q;

  int pass_cnt;
  int tot_cnt;

  cp_flag_servicer #(.CHANNELS(4), .IDW(2), .TIMEOUT(15)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .enable  (enable),
    .flag    (flag),
    .clear   (clear),
    .svc_req (svc_req),
    .svc_id  (svc_id),
    .svc_ack (svc_ack),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Set/clear latch bank: clear wins over set unless the channel is stuck.
  always @(posedge sys_clk) begin
    if (lat_rst) latch_q <= 4'b0000;
    else         latch_q <= (latch_q | set_v) & ~(clear & ~stuck_v);
  end
  assign flag = latch_q;

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; lat_rst = 1'b1; set_v = 4'b0000; stuck_v = 4'b0000;
    enable = 1'b0; svc_ack = 1'b0; err_clr = 1'b0;
    tick(); tick();
    reset_n = 1'b1; lat_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++;
    if ({clear, svc_req, svc_id, busy, err} !== 9'b0000_0_00_0_0) begin
      $display("FAIL reset_outputs: got %b expected %b",
               {clear, svc_req, svc_id, busy, err}, 9'b0000_0_00_0_0);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    enable = 1'b1; set_v = 4'b0001;
    tick();
    tot_cnt++;
    if ({flag, svc_req} !== 5'b0001_0) begin
      $display("FAIL basic_flag_seen: got %b expected %b", {flag, svc_req}, 5'b0001_0);
    end else pass_cnt++;
    set_v = 4'b0000;
    tick();
    tot_cnt++;
    if ({svc_req, svc_id, busy, clear} !== 8'b1_00_1_0000) begin
      $display("FAIL basic_req: got %b expected %b", {svc_req, svc_id, busy, clear}, 8'b1_00_1_0000);
    end else pass_cnt++;
    tick();
    tot_cnt++;
    if ({svc_req, svc_id, clear} !== 7'b1_00_0000) begin
      $display("FAIL basic_req_hold: got %b expected %b", {svc_req, svc_id, clear}, 7'b1_00_0000);
    end else pass_cnt++;
    svc_ack = 1'b1;
    tick();
    tot_cnt++;
    if ({clear, svc_req, busy} !== 6'b0001_0_1) begin
      $display("FAIL basic_clear: got %b expected %b", {clear, svc_req, busy}, 6'b0001_0_1);
    end else pass_cnt++;
    svc_ack = 1'b0;
    tick();
    tot_cnt++;
    if ({clear, flag, busy} !== 9'b0000_0000_1) begin
      $display("FAIL basic_drop: got %b expected %b", {clear, flag, busy}, 9'b0000_0000_1);
    end else pass_cnt++;
    tick();
    tot_cnt++;
    if ({busy, svc_req} !== 2'b00) begin
      $display("FAIL basic_idle: got %b expected %b", {busy, svc_req}, 2'b00);
    end else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ids [5];
    int   n;
    bit   seen;
    logic prev;
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    enable = 1'b1; svc_ack = 1'b1; set_v = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0; seen = 1'b0;
      while (!seen && n < 8) begin
        prev = svc_req;
        tick();
        n++;
        seen = svc_req && !prev;
      end
      tot_cnt++;
      if (!seen || n != ((k == 0) ? 2 : 4) || svc_id !== exp_ids[k]) begin
        $display("FAIL rr_grant%0d: got seen=%0d gap=%0d id=%0d expected gap=%0d id=%0d",
                 k, seen, n, svc_id, ((k == 0) ? 2 : 4), exp_ids[k]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_timeout(input bit clr_same_cycle);
    bit early_err;
    do_reset();
    stuck_v = 4'b0100; set_v = 4'b0100; enable = 1'b1; svc_ack = 1'b1;
    tick();
    set_v = 4'b0000;
    tick();
    enable = 1'b0;
    tot_cnt++;
    if ({svc_req, svc_id} !== 3'b1_10) begin
      $display("FAIL to_req: got %b expected %b", {svc_req, svc_id}, 3'b1_10);
    end else pass_cnt++;
    tick(); tick();
    early_err = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      early_err = early_err | err | ~busy;
    end
    tot_cnt++;
    if (early_err !== 1'b0) begin
      $display("FAIL to_early: got %b expected %b", early_err, 1'b0);
    end else pass_cnt++;
    if (clr_same_cycle) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tot_cnt++;
      if ({err, busy} !== 2'b00) begin
        $display("FAIL clr_same_cycle: got %b expected %b", {err, busy}, 2'b00);
      end else pass_cnt++;
      tick();
      tot_cnt++;
      if (err !== 1'b0) begin
        $display("FAIL clr_same_after: got %b expected %b", err, 1'b0);
      end else pass_cnt++;
    end else begin
      tick();
      tot_cnt++;
      if ({err, busy} !== 2'b10) begin
        $display("FAIL to_err: got %b expected %b", {err, busy}, 2'b10);
      end else pass_cnt++;
      tick();
      tot_cnt++;
      if (err !== 1'b1) begin
        $display("FAIL to_sticky: got %b expected %b", err, 1'b1);
      end else pass_cnt++;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tot_cnt++;
      if (err !== 1'b0) begin
        $display("FAIL to_err_clr: got %b expected %b", err, 1'b0);
      end else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b1; set_v = 4'b0011;
    tick();
    set_v = 4'b0000;
    tick();
    enable = 1'b0;
    tot_cnt++;
    if ({svc_req, svc_id} !== 3'b1_00) begin
      $display("FAIL en_req0: got %b expected %b", {svc_req, svc_id}, 3'b1_00);
    end else pass_cnt++;
    svc_ack = 1'b1;
    tick();
    svc_ack = 1'b0;
    tot_cnt++;
    if (clear !== 4'b0001) begin
      $display("FAIL en_clear0: got %b expected %b", clear, 4'b0001);
    end else pass_cnt++;
    tick(); tick(); tick(); tick(); tick();
    tot_cnt++;
    if ({svc_req, busy, flag} !== 6'b0_0_0010) begin
      $display("FAIL en_hold: got %b expected %b", {svc_req, busy, flag}, 6'b0_0_0010);
    end else pass_cnt++;
    enable = 1'b1;
    tick();
    tot_cnt++;
    if ({svc_req, svc_id} !== 3'b1_01) begin
      $display("FAIL en_req1: got %b expected %b", {svc_req, svc_id}, 3'b1_01);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; svc_ack = 1'b1; set_v = 4'b0001;
    tick();
    set_v = 4'b0000;
    tick(); tick();
    tot_cnt++;
    if ({clear, busy} !== 5'b0001_1) begin
      $display("FAIL rst_mid_clr: got %b expected %b", {clear, busy}, 5'b0001_1);
    end else pass_cnt++;
    reset_n = 1'b0;
    tick();
    tot_cnt++;
    if ({clear, svc_req, busy} !== 6'b0000_0_0) begin
      $display("FAIL rst_mid_drop: got %b expected %b", {clear, svc_req, busy}, 6'b0000_0_0);
    end else pass_cnt++;
    reset_n = 1'b1; set_v = 4'b1000;
    tick();
    set_v = 4'b0000;
    tick();
    tot_cnt++;
    if ({svc_req, svc_id} !== 3'b1_11) begin
      $display("FAIL rst_mid_ch3: got %b expected %b", {svc_req, svc_id}, 3'b1_11);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout(1'b0);
    test_enable();
    test_reset_mid();
    test_timeout(1'b1);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  // Guard against a run that never reaches the summary.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
